spi_sram_responder: RTL and testbench
=====================================

Name: spi_sram_responder

Overview:
- Synthesizable SPI target that emulates a 23LC-style serial SRAM: 8-bit opcode, 24-bit address, data bytes.
- Serves as the far end of the SRAM SPI initiator, for on-chip loopback tests and simulation benches without an external part.
- Oversamples SCLK/CS_N/MOSI with the system clock. Backed by an internal byte array.

Parameters:
- ADDR_W, 8, internal memory address width; DEPTH = 2**ADDR_W bytes. Received address bits [23:ADDR_W] are ignored.
- MODE_RST, 8'h40, reset value of the mode register (sequential mode).

Ports:
- clk  in  1  system clock; must be at least 8x the SCLK frequency.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0); asynchronous to clk.
- cs_n  in  1  chip select, active low; asynchronous.
- mosi  in  1  serial data in; asynchronous.
- miso  out  1  serial data out.
- miso_oe  out  1  high while this block drives read data.
- wr_strobe  out  1  one-clk pulse per committed memory write.
- wr_addr  out  ADDR_W  address of the last committed write.
- wr_data  out  8  data of the last committed write.
- busy  out  1  high while the synchronized cs_n is low.

Behaviour:
- Reset: state IDLE, miso=0, miso_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, mode=MODE_RST, bit counters=0. Memory contents are not reset.
- Input synchronization: 2-flop synchronizers on sclk, cs_n and mosi. Rise/fall events are detected on the synchronized sclk, one clk wide.
- Effective latency from a pin edge to the internal event is 3 clk. A mosi sample is taken with the synchronized sclk rise.
- Bit order is MSB first. The 3-bit bit counter advances on each sclk rise. A byte completes on the 8th rise.
- States:
  - IDLE: on cs_n fall -> CMD, counters cleared.
  - CMD: on byte complete, decode the opcode:
    - 03 (READ) -> ADDR.
    - 02 (WRITE) -> ADDR.
    - 05 (RDSR) -> STAT_RD, with tx_shift loaded from mode.
    - 01 (WRSR) -> STAT_WR.
    - Any other opcode -> IGNORE.
  - ADDR: shifts 24 bits, then:
    - READ -> DATA_RD, with tx_shift = mem[addr] loaded on the 24th address rise.
    - WRITE -> DATA_WR.
  - DATA_RD:
    - On each sclk fall: miso <= tx_shift[7], tx_shift shifts left, miso_oe=1. The first data bit is therefore driven on the fall after the last address bit.
    - On byte complete: addr <= addr+1, wrapping at DEPTH-1 -> 0; tx_shift <= mem[new addr].
  - DATA_WR: on byte complete, mem[addr] <= rx byte, wr_strobe=1 for 1 clk, wr_addr/wr_data updated, then addr increments with the same wrap rule.
  - STAT_RD: drives mode on miso, same timing as DATA_RD. Repeats mode for every further byte.
  - STAT_WR: on byte complete, mode <= rx byte -> IGNORE.
  - IGNORE: miso=0, miso_oe=0 until cs_n rises.
- Mode register bits [7:6]:
  - 00 = byte mode: after one data byte -> IGNORE.
  - 01 = sequential mode.
  - 10/11 treated as sequential.
  - Other bits are stored and read back unchanged.
- cs_n rise, in any state and at any bit position -> IDLE within 1 clk of the synchronized rise. A partial byte is discarded and never written. miso=0, miso_oe=0.
- Write commit takes priority: if cs_n rise and byte complete are detected in the same clk, the complete byte is committed first.
- A WRITE then READ to the same address in a later transaction returns the new data.
- busy = synchronized cs_n inverted.

Decomposition:
- Package spi_sram_pkg:
  - CMD_READ=8'h03, CMD_WRITE=8'h02, CMD_RDSR=8'h05, CMD_WRSR=8'h01.
  - Mode encodings MODE_BYTE=2'b00, MODE_SEQ=2'b01.
  - State enum {IDLE, CMD, ADDR, DATA_RD, DATA_WR, STAT_RD, STAT_WR, IGNORE}.
- Sub-module spi_sync_edge: 2-flop synchronizer plus rise/fall detect, instantiated once each for sclk, cs_n and mosi.

Test Plan:
- WRITE 02,000010,A5 then READ 03,000010 -> one wr_strobe with wr_addr=10, wr_data=A5. Read returns A5 on miso, first bit driven after the 32nd sclk fall.
- Sequential WRITE at 0000FF of 11,22 (ADDR_W=8) then READ at 0000FF of 2 bytes -> writes at FF and 00 (wrap). Read returns 11,22.
- WRSR 01,00 (byte mode), then WRITE at 20 of 33,44 -> only mem[20]=33 and a single wr_strobe. RDSR returns 00. Then WRSR 40, and RDSR returns 40.
- WRITE at 30 with cs_n raised after 5 data bits -> no wr_strobe and mem[30] unchanged. The next transaction decodes its opcode correctly.
- Unknown opcode 9F with 16 further clocks -> miso_oe stays 0 and no writes. Assert rst mid-READ -> miso=0, miso_oe=0, mode=40, state IDLE immediately.
- Address bits above ADDR_W: WRITE at 123456 data 5A -> wr_addr=56. READ at 000056 returns 5A.

Source files
------------

// File: rtl/spi_sram_pkg.sv
// Shared opcodes, mode encodings and FSM state type for the SPI serial-SRAM responder.
package spi_sram_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [7:0] CMD_WRSR  = 8'h01;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_SEQ  = 2'b01;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DATA_RD, DATA_WR, STAT_RD, STAT_WR, IGNORE
  } state_t;

  // Mode bits [7:6]: 00 stops after one data byte, every other value streams.
  function automatic logic is_byte_mode(input logic [7:0] mode);
    return mode[7:6] == MODE_BYTE;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus one-clk rise/fall pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta, sync, prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 target emulating a 23LC-style serial SRAM (READ/WRITE/RDSR/WRSR)
// over an internal byte array, with all SPI pins oversampled by clk.
module spi_sram_responder
  import spi_sram_pkg::*;
#(
  parameter int         ADDR_W   = 8,
  parameter logic [7:0] MODE_RST = 8'h40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output state_t            state
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk), .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs_n), .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi), .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  wire unused = ^{sclk_level, cs_rise, mosi_rise, mosi_fall};

  logic [7:0]        mem [DEPTH];
  state_t            next_state;
  logic [2:0]        bit_cnt;
  logic [1:0]        addr_bytes;
  logic [7:0]        rx_shift, tx_shift, mode;
  logic [ADDR_W-1:0] addr;
  logic              is_read;

  logic              byte_done, addr_done;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] addr_shifted, addr_inc;
  logic              do_commit, load_mode, shift_out, clear_out;

  assign byte_done    = sclk_rise && (bit_cnt == 3'd7);
  assign addr_done    = byte_done && (addr_bytes == 2'd2);
  assign rx_byte      = {rx_shift[6:0], mosi_s};
  // Only the low ADDR_W of the 24 received address bits survive the shift.
  assign addr_shifted = {addr[ADDR_W-2:0], mosi_s};
  assign addr_inc     = addr + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign busy         = ~cs_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cs_fall) next_state = CMD;
      CMD:
        if (byte_done) begin
          case (rx_byte)
            CMD_READ, CMD_WRITE: next_state = ADDR;
            CMD_RDSR:            next_state = STAT_RD;
            CMD_WRSR:            next_state = STAT_WR;
            default:             next_state = IGNORE;
          endcase
        end
      ADDR:    if (addr_done) next_state = is_read ? DATA_RD : DATA_WR;
      DATA_RD, DATA_WR:
        if (byte_done && is_byte_mode(mode)) next_state = IGNORE;
      STAT_WR: if (byte_done) next_state = IGNORE;
      default: next_state = state;
    endcase
    // Deselect wins over every transition; datapath commits still happen this clk.
    if (state != IDLE && cs_level) next_state = IDLE;
  end

  always_comb begin
    do_commit = (state == DATA_WR) && byte_done;
    load_mode = (state == STAT_WR) && byte_done;
    shift_out = (state == DATA_RD || state == STAT_RD) && sclk_fall && !cs_level;
    clear_out = !(state == DATA_RD || state == STAT_RD) || cs_level;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= 3'd0;
      addr_bytes <= 2'd0;
      rx_shift   <= 8'd0;
      tx_shift   <= 8'd0;
      addr       <= '0;
      is_read    <= 1'b0;
      mode       <= MODE_RST;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'd0;
    end else begin
      wr_strobe <= 1'b0;
      if (state == IDLE) begin
        bit_cnt    <= 3'd0;
        addr_bytes <= 2'd0;
      end else if (sclk_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= rx_byte;
      end
      if (state == ADDR && sclk_rise) begin
        addr <= addr_shifted;
        if (bit_cnt == 3'd7) addr_bytes <= addr_bytes + 2'd1;
      end
      if (state == CMD && byte_done) is_read <= (rx_byte == CMD_READ);
      if (do_commit) begin
        wr_strobe <= 1'b1;
        wr_addr   <= addr;
        wr_data   <= rx_byte;
        addr      <= addr_inc;
      end
      if (state == DATA_RD && byte_done) addr <= addr_inc;
      if (load_mode) mode <= rx_byte;

      if (state == CMD && byte_done && rx_byte == CMD_RDSR) tx_shift <= mode;
      else if (state == ADDR && addr_done && is_read)      tx_shift <= mem[addr_shifted];
      else if (state == DATA_RD && byte_done)              tx_shift <= mem[addr_inc];
      else if (state == STAT_RD && byte_done)              tx_shift <= mode;
      else if (shift_out)                                  tx_shift <= {tx_shift[6:0], 1'b0};

      if (clear_out) begin
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end else if (shift_out) begin
        miso    <= tx_shift[7];
        miso_oe <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_commit) mem[addr] <= rx_byte;
  end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Scoreboard bench for spi_sram_responder: directed SPI transactions push expected
// writes/read bytes into queues that independent monitors pop and compare.
module tb_spi_sram_responder;
  import spi_sram_pkg::*;

  localparam int ADDR_W = 8;
  localparam int HALF   = 50;

  logic              clk = 1'b0;
  logic              rst;
  logic              sclk, cs_n, mosi;
  logic              miso, miso_oe, wr_strobe, busy;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  state_t            state;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int oe_cnt   = 0;

  logic [7:0]        exp_rd_q[$];
  logic [ADDR_W+7:0] exp_wr_q[$];

  spi_sram_responder #(.ADDR_W(ADDR_W), .MODE_RST(8'h40)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Write monitor: each strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (miso_oe) oe_cnt++;
    if (wr_strobe) begin
      wr_cnt++;
      if (exp_wr_q.size() == 0) check("unexpected_write", {wr_addr, wr_data}, 32'hFFFF_FFFF);
      else check("write", {wr_addr, wr_data}, exp_wr_q.pop_front());
    end
  end

  // Read monitor: collects miso bits at sclk rises while driven, byte by byte.
  logic [7:0] rd_byte;
  int         rd_bits;
  always @(posedge sclk or posedge cs_n or posedge rst) begin
    if (rst || cs_n) begin
      rd_bits = 0;
      rd_byte = 8'h00;
    end else if (miso_oe) begin
      rd_byte = {rd_byte[6:0], miso};
      rd_bits++;
      if (rd_bits == 8) begin
        rd_bits = 0;
        if (exp_rd_q.size() == 0) check("unexpected_read", {24'd0, rd_byte}, 32'hFFFF_FFFF);
        else check("read_byte", {24'd0, rd_byte}, {24'd0, exp_rd_q.pop_front()});
      end
    end
  end

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      #(HALF); sclk = 1'b1;
      #(HALF); sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    spi_bits(b, 8);
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    #(2 * HALF);
  endtask

  task automatic cs_end();
    #(HALF); cs_n = 1'b1;
    #(4 * HALF);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
    spi_byte(op);
    spi_byte(a[23:16]);
    spi_byte(a[15:8]);
    spi_byte(a[7:0]);
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_state", {29'd0, state}, {29'd0, IDLE});
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // WRITE A5 @10, then READ it back with first-bit timing check.
    exp_wr_q.push_back({8'h10, 8'hA5});
    cs_begin(); send_hdr(8'h02, 24'h000010); spi_byte(8'hA5); cs_end();
    exp_rd_q.push_back(8'hA5);
    cs_begin();
    check("busy_selected", {31'd0, busy}, 32'd1);
    send_hdr(8'h03, 24'h000010);
    check("oe_before_first_fall", {31'd0, miso_oe}, 32'd0);
    #(HALF - 10);
    check("oe_after_first_fall", {31'd0, miso_oe}, 32'd1);
    check("first_bit", {31'd0, miso}, 32'd1);
    spi_byte(8'h00); cs_end();

    // Sequential write across the top of memory wraps to 00.
    exp_wr_q.push_back({8'hFF, 8'h11});
    exp_wr_q.push_back({8'h00, 8'h22});
    cs_begin(); send_hdr(8'h02, 24'h0000FF); spi_byte(8'h11); spi_byte(8'h22); cs_end();
    exp_rd_q.push_back(8'h11);
    exp_rd_q.push_back(8'h22);
    cs_begin(); send_hdr(8'h03, 24'h0000FF); spi_byte(8'h00); spi_byte(8'h00); cs_end();

    // Byte mode: only the first data byte is written or read.
    cs_begin(); spi_byte(8'h01); spi_byte(8'h00); cs_end();
    exp_wr_q.push_back({8'h20, 8'h33});
    cs_begin(); send_hdr(8'h02, 24'h000020); spi_byte(8'h33); spi_byte(8'h44); cs_end();
    exp_rd_q.push_back(8'h00);
    cs_begin(); spi_byte(8'h05); spi_byte(8'h00); cs_end();
    exp_rd_q.push_back(8'h33);
    cs_begin(); send_hdr(8'h03, 24'h000020); spi_byte(8'h00); cs_end();
    cs_begin(); spi_byte(8'h01); spi_byte(8'h40); cs_end();
    exp_rd_q.push_back(8'h40);
    exp_rd_q.push_back(8'h40);
    cs_begin(); spi_byte(8'h05); spi_byte(8'h00); spi_byte(8'h00); cs_end();

    // Partial byte aborted by deselect must never reach memory.
    exp_wr_q.push_back({8'h30, 8'h77});
    cs_begin(); send_hdr(8'h02, 24'h000030); spi_byte(8'h77); cs_end();
    cs_begin(); send_hdr(8'h02, 24'h000030); spi_bits(8'hFF, 5); cs_end();
    exp_rd_q.push_back(8'h77);
    cs_begin(); send_hdr(8'h03, 24'h000030); spi_byte(8'h00); cs_end();

    // Unknown opcode: no drive, no writes.
    oe_cnt = 0;
    cs_begin(); spi_byte(8'h9F); spi_byte(8'hFF); spi_byte(8'h02); cs_end();
    check("ignore_no_oe", oe_cnt, 32'd0);
    check("ignore_state_idle", {29'd0, state}, {29'd0, IDLE});

    // Upper address bits are dropped.
    exp_wr_q.push_back({8'h56, 8'h5A});
    cs_begin(); send_hdr(8'h02, 24'h123456); spi_byte(8'h5A); cs_end();
    exp_rd_q.push_back(8'h5A);
    cs_begin(); send_hdr(8'h03, 24'h000056); spi_byte(8'h00); cs_end();

    // Reset in the middle of a read restores mode and silences miso at once.
    cs_begin(); spi_byte(8'h01); spi_byte(8'h80); cs_end();
    cs_begin(); send_hdr(8'h03, 24'h000010); spi_bits(8'h00, 3);
    check("pre_rst_oe", {31'd0, miso_oe}, 32'd1);
    #3; rst = 1'b1; #1;
    check("rst_mid_miso", {31'd0, miso}, 32'd0);
    check("rst_mid_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_mid_state", {29'd0, state}, {29'd0, IDLE});
    cs_n = 1'b1;
    #(2 * HALF); rst = 1'b0;
    #(2 * HALF);
    exp_rd_q.push_back(8'h40);
    cs_begin(); spi_byte(8'h05); spi_byte(8'h00); cs_end();

    #(4 * HALF);
    check("wr_queue_empty", exp_wr_q.size(), 32'd0);
    check("rd_queue_empty", exp_rd_q.size(), 32'd0);
    check("write_count", wr_cnt, 32'd6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
